// File: rtl/dual_port_ram_32x1024.sv
// rtl/dual_port_ram_32x1024.sv - simple dual-port 1024x32 RAM, write port A, registered read port B
// Holds the DOUT waveform table; contents survive reset, only the read register clears.
module dual_port_ram_32x1024 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Power-up contents are all zero; the declaration initialiser maps onto the block RAM init.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] doutb_q = '0;

  always_ff @(posedge sysclk) begin
    if (ena && wea) begin
      mem[addra] <= dina;
    end
  end

  // Read samples the pre-write contents, giving read-first behaviour on an address collision.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      doutb_q <= '0;
    end else if (enb) begin
      doutb_q <= mem[addrb];
    end
  end

  assign doutb = doutb_q;

endmodule

// File: tb/tb_dual_port_ram_32x1024.sv
// tb/tb_dual_port_ram_32x1024.sv - scoreboard bench for dual_port_ram_32x1024
// Stimulus pushes the expected post-edge doutb for every cycle; a monitor pops and compares.
module tb_dual_port_ram_32x1024;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [9:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        enb = 1'b0;
  logic [9:0]  addrb = '0;
  logic [31:0] doutb;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [1024];
  logic [31:0] exp_dout = '0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  string       cur_tag = "init";

  dual_port_ram_32x1024 dut (
    .sysclk (sysclk),
    .reset  (reset),
    .ena    (ena),
    .wea    (wea),
    .addra  (addra),
    .dina   (dina),
    .enb    (enb),
    .addrb  (addrb),
    .doutb  (doutb)
  );

  always #5 sysclk = ~sysclk;

  // One clock of stimulus; the reference is a plain word array with read-before-write ordering.
  task automatic drive(input logic r, input logic e_a, input logic w_a, input logic [9:0] aa,
                       input logic [31:0] da, input logic e_b, input logic [9:0] ab);
    @(negedge sysclk);
    reset = r; ena = e_a; wea = w_a; addra = aa; dina = da; enb = e_b; addrb = ab;
    if (r) exp_dout = 32'h0;
    else if (e_b) exp_dout = model[ab];
    if (e_a && w_a) model[aa] = da;
    exp_q.push_back(exp_dout);
    tag_q.push_back(cur_tag);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b1, a, d, 1'b0, 10'd0);
  endtask

  task automatic rd(input logic [9:0] a);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, a);
  endtask

  always @(posedge sysclk) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      if (doutb !== e) begin
        miscompares++;
        $display("FAIL %s: doutb=%08h expected %08h at %0t", t, doutb, e, $time);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;

    #1;
    vectors++;
    if (doutb !== 32'h0) begin
      miscompares++;
      $display("FAIL powerup: doutb=%08h expected 00000000", doutb);
    end

    cur_tag = "idle";
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
    rd(10'd512);

    cur_tag = "write_read";
    wr(10'd0, 32'h80000155);
    wr(10'd1, 32'h00000A02);
    wr(10'd1023, 32'hFFFFFFFF);
    rd(10'd0); rd(10'd1); rd(10'd1023);

    cur_tag = "write_gating";
    drive(1'b0, 1'b1, 1'b0, 10'd5, 32'h12345678, 1'b0, 10'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd5, 32'h12345678, 1'b0, 10'd0);
    rd(10'd5);

    cur_tag = "read_first";
    wr(10'd7, 32'hAAAA0000);
    drive(1'b0, 1'b1, 1'b1, 10'd7, 32'h5555FFFF, 1'b1, 10'd7);
    rd(10'd7);

    cur_tag = "hold";
    rd(10'd1);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
    rd(10'd0);

    cur_tag = "reset";
    rd(10'd1023);
    drive(1'b1, 1'b1, 1'b1, 10'd9, 32'hCAFEF00D, 1'b1, 10'd1023);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
    rd(10'd1023);
    rd(10'd9);

    cur_tag = "sweep";
    for (int i = 0; i < 1024; i++) wr(10'(i), 32'(i) * 32'h00010001);
    for (int i = 0; i < 1024; i++) rd(10'(i));

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
            10'($urandom_range(0, 15)), $urandom, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15)));
    end

    @(negedge sysclk);
    enb = 1'b0; ena = 1'b0; wea = 1'b0; reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_32x1024.md
Name: dual_port_ram_32x1024

Overview:
Simple dual-port synchronous RAM, 1024 words x 32 bits. Port A is write-only and port B is read-only; both run on the single system clock.
In the digital-output controller it stores the DOUT waveform table. The host writes the table through port A. Port B is read either by the waveform sequencer or by the host register-read path.
Entry format (informative only; the RAM does not interpret it): valid[31], end_cnt[30:8], dout[7:0].

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH = 1024 words

Ports:
sysclk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears the port-B output register only
ena  input  1  port A enable
wea  input  1  port A write enable; write occurs only when ena=1 and wea=1
addra  input  ADDR_WIDTH  port A write address
dina  input  DATA_WIDTH  port A write data
enb  input  1  port B enable (read / output-register update)
addrb  input  ADDR_WIDTH  port B read address
doutb  output  DATA_WIDTH  port B registered read data

Behaviour:
- Storage: mem[0:1023] of 32 bits. All words initialise to 0 at configuration/power-up. reset does NOT clear memory contents.
- Write: on a rising edge with ena=1 and wea=1, mem[addra] <= dina. Otherwise memory is unchanged.
- Read: on a rising edge with enb=1, doutb <= mem[addrb]. Latency is exactly 1 clock: an address presented in cycle N gives its data on doutb after edge N+1, stable for all of cycle N+1.
- enb=0: doutb holds its previous value.
- reset=1 on a rising edge: doutb <= 0. Reset has priority over enb. A port-A write in the same cycle still completes, because memory is unaffected by reset.
- doutb is 0 after power-up, before any read.
- Read-during-write to the same address in the same cycle is read-first: doutb returns the old contents, and the new data is visible on a read issued in the following cycle.
- Read and write to different addresses in the same cycle are fully independent.
- Addresses are exactly ADDR_WIDTH bits. No out-of-range case exists; 1023 is the last word and there is no wrap logic inside the RAM.
- No combinational path from any input to doutb.
- Writes on consecutive cycles and back-to-back reads on consecutive cycles (new address every clock) are supported at full rate.
- Implementation infers a single block RAM (simple dual-port, one clock).

Test Plan:
1. Write-then-read: write 0x80000155 to addr 0, 0x00000A02 to addr 1 and 0xFFFFFFFF to addr 1023. Then read addrb=0,1,1023 on consecutive cycles -> doutb = 0x80000155, 0x00000A02, 0xFFFFFFFF, each one cycle after its address.
2. Write gating: ena=1, wea=0, dina=0x12345678, addra=5 -> a later read of addr 5 returns 0. Repeat with ena=0, wea=1 -> still 0.
3. Read-first collision: mem[7]=0xAAAA0000. In one cycle write 0x5555FFFF to addr 7 and read addr 7 -> doutb=0xAAAA0000. Next-cycle read of addr 7 -> doutb=0x5555FFFF.
4. Output hold: read addr 1 (doutb=0x00000A02), then drop enb to 0 and change addrb to 0 -> doutb stays 0x00000A02 until enb returns to 1.
5. Reset: with doutb=0xFFFFFFFF, assert reset for 1 cycle with enb=1 -> doutb=0. After reset release, a read of addr 1023 returns 0xFFFFFFFF (contents retained).
6. Full sweep: write mem[i]=i*0x00010001 for i=0..1023 on back-to-back cycles. Read sequentially back-to-back -> every word matches with exactly 1-cycle latency, including address 1023.
